// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: write-back trace buffer with halt-sentinel and cycle-budget watchdog; WBMON_SIGNATURE_EN adds a rolling signature that qualifies pass
module wb_trace_monitor #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int MAX_CYCLES = 65,
  parameter logic [DATA_W-1:0] HALT_VALUE = 32'hC0DE_D00E,
  parameter int HALT_REPEAT = 2,
  parameter logic [DATA_W-1:0] EXP_SIG = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_valid,
  input  logic                     freeze,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic                     wrapped,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [DATA_W-1:0]        signature
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HALT_REPEAT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [HW-1:0] HREP = HW'(HALT_REPEAT);
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, HALTED, TOUT} state_t;
  state_t cur, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic run, cap;
  assign run = cur == RUN;
  assign cap = run && wb_valid && !freeze;
  assign state = cur;
  assign done = cur == HALTED || cur == TOUT;
  assign timeout = cur == TOUT;
  always_comb begin
    hcnt_nxt = !wb_valid ? hcnt : (wb_data != HALT_VALUE) ? '0 : (hcnt == HREP) ? hcnt : hcnt + 1'b1;
    nxt = (cur == IDLE) ? RUN : !run ? cur : (hcnt_nxt == HREP) ? HALTED : (cycle_count == LAST) ? TOUT : RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  // count saturates at the budget edge so a timed-out run reports MAX_CYCLES-1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      wrapped <= 1'b0;
      cycle_count <= '0;
      hcnt <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (run) begin
        cycle_count <= (cycle_count == LAST) ? cycle_count : cycle_count + 1'b1;
        hcnt <= hcnt_nxt;
      end
      if (cap) begin
        wr_ptr <= wr_ptr + 1'b1;
        wrapped <= wrapped || wr_ptr == TOP;
      end
    end
  always_ff @(posedge clk)
    if (cap) mem[wr_ptr] <= wb_data;
`ifdef WBMON_SIGNATURE_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) signature <= '0;
    else if (cap) signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ wb_data;
  assign pass = cur == HALTED && signature == EXP_SIG;
`else
  assign signature = '0;
  assign pass = cur == HALTED;
`endif
endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb_wb_trace_monitor: table vectors, directed corner sequences and random runs against a trace-history model
module tb_wb_trace_monitor;
  localparam int DEPTH = 16;
  localparam int MAXC = 65;
  localparam int HREP = 2;
  localparam logic [31:0] HALT = 32'hC0DE_D00E;
  logic clk = 0, reset = 1, wb_valid = 0, freeze = 0;
  logic [31:0] wb_data = 0, rd_data, signature;
  logic [3:0] rd_addr = 0, wr_ptr;
  logic wrapped, done, pass, timeout;
  logic [15:0] cycle_count;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  int m_st, m_cyc, m_run;
  logic [31:0] m_sig;
  logic [31:0] hist [$];
  typedef struct {
    bit rst;
    logic [31:0] d;
    logic v, f;
    logic [1:0] st;
    logic [3:0] ptr;
    logic dn;
  } vec_t;
  vec_t tv [13];

  wb_trace_monitor dut (
    .clk(clk), .reset(reset), .wb_data(wb_data), .wb_valid(wb_valid), .freeze(freeze),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_ptr(wr_ptr), .wrapped(wrapped),
    .cycle_count(cycle_count), .state(state), .done(done), .pass(pass),
    .timeout(timeout), .signature(signature)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 64'(state), 0);
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 0);
    chk({tag, "_wrapped"}, 64'(wrapped), 0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 0);
    chk({tag, "_flags"}, {61'd0, done, pass, timeout}, 0);
    chk({tag, "_signature"}, 64'(signature), 0);
    chk({tag, "_rd_data"}, 64'(rd_data), 0);
  endtask

  function automatic void model_clear();
    hist.delete();
    m_st = 0;
    m_cyc = 0;
    m_run = 0;
    m_sig = 0;
  endfunction

  task automatic check_model(input bit known, input logic [31:0] erd);
    logic [31:0] esig;
    bit epass;
`ifdef WBMON_SIGNATURE_EN
    esig = m_sig;
    epass = m_st == 2 && m_sig == 32'h0;
`else
    esig = 0;
    epass = m_st == 2;
`endif
    chk("state", 64'(state), 64'(m_st));
    chk("wr_ptr", 64'(wr_ptr), 64'(hist.size() % DEPTH));
    chk("wrapped", 64'(wrapped), 64'(hist.size() >= DEPTH));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("done", 64'(done), 64'(m_st >= 2));
    chk("timeout", 64'(timeout), 64'(m_st == 3));
    chk("pass", 64'(pass), 64'(epass));
    chk("signature", 64'(signature), 64'(esig));
    if (known) chk("rd_data", 64'(rd_data), 64'(erd));
  endtask

  task automatic step(input logic v, input logic f, input logic [31:0] d, input logic [3:0] a);
    logic [31:0] erd;
    bit known, budget;
    wb_valid = v;
    freeze = f;
    wb_data = d;
    rd_addr = a;
    known = 0;
    erd = 0;
    for (int k = 0; k < hist.size(); k++)
      if (k % DEPTH == int'(a)) begin
        erd = hist[k];
        known = 1;
      end
    @(posedge clk);
    if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      budget = m_cyc == MAXC - 1;
      if (v) m_run = (d == HALT) ? m_run + 1 : 0;
      if (v && !f) begin
        hist.push_back(d);
        m_sig = {m_sig[30:0], m_sig[31]} ^ d;
      end
      if (!budget) m_cyc++;
      m_st = (m_run >= HREP) ? 2 : budget ? 3 : 1;
    end
    @(negedge clk);
    check_model(known, erd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1;
    #2 chk_zero("rst");
    model_clear();
    @(negedge clk);
    reset = 0;
    step(0, 0, 0, 0);
  endtask

  initial begin
    tv[0]  = '{1'b0, 32'd5, 1'b1, 1'b0, 2'd1, 4'd1, 1'b0};
    tv[1]  = '{1'b0, HALT,  1'b1, 1'b0, 2'd1, 4'd2, 1'b0};
    tv[2]  = '{1'b0, 32'd7, 1'b1, 1'b0, 2'd1, 4'd3, 1'b0};
    tv[3]  = '{1'b0, HALT,  1'b1, 1'b0, 2'd1, 4'd4, 1'b0};
    tv[4]  = '{1'b0, HALT,  1'b1, 1'b0, 2'd2, 4'd5, 1'b1};
    tv[5]  = '{1'b0, 32'd9, 1'b1, 1'b0, 2'd2, 4'd5, 1'b1};
    tv[6]  = '{1'b1, 32'd1, 1'b1, 1'b0, 2'd1, 4'd1, 1'b0};
    tv[7]  = '{1'b0, HALT,  1'b1, 1'b1, 2'd1, 4'd1, 1'b0};
    tv[8]  = '{1'b0, HALT,  1'b1, 1'b1, 2'd2, 4'd1, 1'b1};
    tv[9]  = '{1'b1, HALT,  1'b1, 1'b0, 2'd1, 4'd1, 1'b0};
    tv[10] = '{1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0};
    tv[11] = '{1'b0, 32'd55, 1'b0, 1'b1, 2'd1, 4'd1, 1'b0};
    tv[12] = '{1'b0, HALT,  1'b1, 1'b0, 2'd2, 4'd2, 1'b1};
    model_clear();
    #15 chk_zero("init");
    #10 reset = 0;
    step(0, 0, 0, 0);
    chk("enter_run_state", 64'(state), 1);
    chk("enter_run_count", 64'(cycle_count), 0);

    for (int i = 0; i < 20; i++) step(1, 0, 32'(i + 1), 4'(i));
    chk("wrap_ptr", 64'(wr_ptr), 4);
    chk("wrap_flag", 64'(wrapped), 1);
    for (int a = 0; a < 5; a++) begin
      step(0, 0, 0, 4'(a));
      chk("rd_slot", 64'(rd_data), (a < 4) ? 64'(17 + a) : 64'd5);
    end

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (tv[i].rst) do_reset();
      step(tv[i].v, tv[i].f, tv[i].d, 4'(i));
      chk("tv_state", 64'(state), 64'(tv[i].st));
      chk("tv_wr_ptr", 64'(wr_ptr), 64'(tv[i].ptr));
      chk("tv_done", 64'(done), 64'(tv[i].dn));
    end

    do_reset();
    for (int i = 0; i < 200 && m_st == 1; i++) step(0, 0, 0, 0);
    chk("tout_state", 64'(state), 3);
    chk("tout_flag", 64'(timeout), 1);
    chk("tout_pass", 64'(pass), 0);
    chk("tout_count", 64'(cycle_count), 64);

    do_reset();
    for (int i = 0; i < 200 && m_cyc < 63; i++) step(1, 0, 32'(i), 0);
    step(1, 0, HALT, 0);
    step(1, 0, HALT, 0);
    chk("late_halt_state", 64'(state), 2);
    chk("late_halt_count", 64'(cycle_count), 64);
    chk("late_halt_timeout", 64'(timeout), 0);

    for (int r = 0; r < 6; r++) begin
      int extra;
      do_reset();
      extra = 0;
      for (int i = 0; i < 150 && extra < 3; i++) begin
        logic [31:0] d;
        d = ($urandom_range(0, (r % 2 == 0) ? 9 : 2) == 0) ? HALT : 32'($urandom);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, d, 4'($urandom_range(0, 15)));
        if (m_st >= 2) extra++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
